h75_scan_engine: RTL and testbench
==================================

H75_SCAN_ENGINE -- requirements
Module: h75_scan_engine

Interface
REQ-001 SHALL have parameter ROW_BITS, default 5, meaning scan address width; rows per plane = 2**ROW_BITS.
REQ-002 SHALL have parameter PLANES, default 6, range 1..8, meaning bit planes per frame, plane index PLANES-1 (MSB) down to 0.
REQ-003 SHALL have parameter X_BITS, default 9, meaning pixel column address width.
REQ-004 SHALL have parameter RD_LAT, default 2, range 1..4, meaning frame-RAM read latency in clocks.
REQ-005 SHALL have parameter BASE_W, default 12, meaning width of bcm_base.
REQ-006 SHALL have ports: clk in 1 system clock; resetn in 1 asynchronous active-low reset.
REQ-007 SHALL have ports: gen_timing in 1 frame enable; pixels_per_row in X_BITS+1 clocks shifted per row (valid 2..2**X_BITS); bcm_base in BASE_W on-time of plane 0 in clocks; brightness in 8 global dimming (255 = full); guard in 4 dead clocks between OE off and row change.
REQ-008 SHALL have ports: frame_sync out 1; plane out 3; rd_addr out ROW_BITS+X_BITS = {row, x}; rd_en out 1.
REQ-009 SHALL have ports: oe_n out 1 panel blank (low = LEDs on); latch_enable out 1; led_clk_en out 1 enable for the output DDR clock cell; ABCDE out ROW_BITS; busy out 1 high from frame start until IDLE.

Function
REQ-010 SHALL use states IDLE, START, SHIFT, DRAIN, WAIT_OE, GUARD, LATCH, ARM, NEXT.
REQ-011 IDLE: when gen_timing=1 and OE inactive, assert frame_sync for 4 clocks (START), then plane=PLANES-1, row=0, enter SHIFT.
REQ-012 SHIFT: rd_en=1, x increments 0..pixels_per_row-1, one per clock; x=pixels_per_row-1 -> DRAIN.
REQ-013 led_clk_en SHALL equal rd_en delayed RD_LAT clocks, so exactly pixels_per_row enabled clock edges occur per row.
REQ-014 DRAIN: hold RD_LAT clocks, then WAIT_OE.
REQ-015 WAIT_OE: stay until OE timer expired; then GUARD.
REQ-016 GUARD: count guard clocks (0 = skip), oe_n held high; then ABCDE<=row, LATCH.
REQ-017 LATCH: latch_enable=1 exactly one clock; then ARM.
REQ-018 ARM: load on-time counter = (bcm_base << plane) * brightness >> 8, computed at width BASE_W+8+8, saturating at 2**24-1; oe_n=0 next clock if result nonzero; then NEXT.
REQ-019 On-time counter SHALL decrement while OE active; oe_n returns high the clock the counter reaches 0; brightness=0 SHALL keep oe_n high the whole frame.
REQ-020 NEXT: row<2**ROW_BITS-1 -> row+1, SHIFT (shift of next row overlaps current OE); last row and plane>0 -> plane-1, row=0, SHIFT; last row and plane=0 -> IDLE.
REQ-021 Row wrap SHALL be exact at 2**ROW_BITS-1; x and row counters never exceed range.
REQ-022 gen_timing deassertion mid-frame SHALL complete the current frame, then stay IDLE.
REQ-023 pixels_per_row, bcm_base, brightness, guard SHALL be sampled at frame start and held for the frame.
REQ-024 Successive frames with gen_timing held high SHALL restart only after final OE expires.

Reset
REQ-025 On resetn=0 asynchronously: state IDLE, oe_n=1, latch_enable=0, led_clk_en=0, rd_en=0, frame_sync=0, busy=0, plane=0, ABCDE=0, rd_addr=0, all counters 0.
REQ-026 Reset mid-frame SHALL blank the panel immediately (oe_n=1 asynchronously).

Structure
REQ-027 State encoding and default parameter constants SHALL reside in shared package h75_pkg.
REQ-028 On-time counter and multiply SHALL be sub-module h75_bcm_timer (load, value, active out).
REQ-029 No latches or derived clocks; led_clk_en only, clocking done by output DDR cell.

Verification
REQ-030 ROW_BITS=2, PLANES=2, ppr=4, base=8, bright=255, guard=0 -> 8 latches/frame, 4 led_clk_en pulses per row, on-times 15 and 7 (8<<1*255>>8=15; 8*255>>8=7).
REQ-031 brightness=0 -> oe_n never low; latch count and ABCDE sequence unchanged.
REQ-032 guard=5 -> >=5 clocks between oe_n rising and ABCDE change every row.
REQ-033 gen_timing dropped at row 1 plane 1 -> frame finishes all planes, busy falls, no new frame_sync.
REQ-034 resetn pulsed during OE -> oe_n high same cycle, all outputs at reset values, clean frame after release.
REQ-035 RD_LAT=3, ppr=64 -> led_clk_en rises 3 clocks after rd_en, 64 pulses exactly.

Source files
------------

// File: rtl/h75_pkg.sv
// Shared scan-engine constants and FSM state encoding for the HUB75 scan engine.
package h75_pkg;

  localparam int unsigned H75_ROW_BITS = 5;
  localparam int unsigned H75_PLANES   = 6;
  localparam int unsigned H75_X_BITS   = 9;
  localparam int unsigned H75_RD_LAT   = 2;
  localparam int unsigned H75_BASE_W   = 12;

  localparam int unsigned ONTIME_W   = 24;
  localparam int unsigned START_CLKS = 4;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [3:0] {
    IDLE,
    START,
    SHIFT,
    DRAIN,
    WAIT_OE,
    GUARD,
    LATCH,
    ARM,
    NEXT
  } scan_state_e;

endpackage

// File: rtl/h75_bcm_timer.sv
// Binary-code-modulation on-time timer: scales the plane weight by brightness
// and counts the panel-enable window down to zero.
module h75_bcm_timer
  import h75_pkg::*;
#(
  parameter int unsigned BASE_W = H75_BASE_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                load,
  input  logic [BASE_W-1:0]   base,
  input  logic [2:0]          plane,
  input  logic [7:0]          brightness,
  output logic [ONTIME_W-1:0] value,
  output logic                active
);

  localparam int unsigned MW = BASE_W + 16;
  localparam int unsigned CW = (MW > ONTIME_W + 1) ? MW : ONTIME_W + 1;
  localparam logic [CW-1:0] SAT = CW'({ONTIME_W{1'b1}});

  logic [CW-1:0]       scaled_c;
  logic [ONTIME_W-1:0] load_val_c;
  logic [ONTIME_W-1:0] value_d;

  // (base << plane) * brightness / 256, clamped to the counter range
  always_comb begin
    scaled_c   = ((CW'(base) << plane) * CW'(brightness)) >> 8;
    load_val_c = (scaled_c > SAT) ? {ONTIME_W{1'b1}} : scaled_c[ONTIME_W-1:0];
    value_d    = value;
    if (load) begin
      value_d = load_val_c;
    end else if (value != '0) begin
      value_d = value - ONTIME_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value  <= '0;
      active <= 1'b0;
    end else begin
      value  <= value_d;
      active <= (value_d != '0);
    end
  end

endmodule

// File: rtl/h75_scan_engine.sv
// HUB75 panel scan engine: walks planes and rows, fetches pixel columns,
// latches each row and gates OE for a brightness-scaled BCM on-time.
module h75_scan_engine
  import h75_pkg::*;
#(
  parameter int unsigned ROW_BITS = H75_ROW_BITS,
  parameter int unsigned PLANES   = H75_PLANES,
  parameter int unsigned X_BITS   = H75_X_BITS,
  parameter int unsigned RD_LAT   = H75_RD_LAT,
  parameter int unsigned BASE_W   = H75_BASE_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       gen_timing,
  input  logic [X_BITS:0]            pixels_per_row,
  input  logic [BASE_W-1:0]          bcm_base,
  input  logic [7:0]                 brightness,
  input  logic [3:0]                 guard,
  output logic                       frame_sync,
  output logic [2:0]                 plane,
  output logic [ROW_BITS+X_BITS-1:0] rd_addr,
  output logic                       rd_en,
  output logic                       oe_n,
  output logic                       latch_enable,
  output logic                       led_clk_en,
  output logic [ROW_BITS-1:0]        ABCDE,
  output logic                       busy
);

  localparam int unsigned PW = X_BITS + 1;

  scan_state_e         state_q, state_d;
  logic [X_BITS-1:0]   x_q, x_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [2:0]          plane_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tmr_load_c;

  logic [PW-1:0]       ppr_s;
  logic [BASE_W-1:0]   base_s;
  logic [7:0]          bright_s;
  logic [3:0]          guard_s;

  logic [RD_LAT-1:0]   led_pipe;
  logic [ONTIME_W-1:0] tmr_value;
  logic                tmr_active;

  h75_bcm_timer #(.BASE_W(BASE_W)) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .load       (tmr_load_c),
    .base       (base_s),
    .plane      (plane),
    .brightness (bright_s),
    .value      (tmr_value),
    .active     (tmr_active)
  );

  // Reset clears the timer flop asynchronously, so the panel blanks at once
  assign oe_n       = ~tmr_active;
  assign led_clk_en = led_pipe[RD_LAT-1];

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    row_d      = row_q;
    plane_d    = plane;
    cnt_d      = cnt_q;
    tmr_load_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gen_timing && (tmr_value == '0)) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_W'(START_CLKS - 1)) begin
          state_d = SHIFT;
          plane_d = 3'(PLANES - 1);
          row_d   = '0;
          x_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if ({1'b0, x_q} == ppr_s - PW'(1)) begin
          state_d = DRAIN;
          x_d     = '0;
          cnt_d   = '0;
        end else begin
          x_d = x_q + X_BITS'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) state_d = WAIT_OE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      WAIT_OE: begin
        if (tmr_value == '0) begin
          cnt_d   = '0;
          state_d = (guard_s == '0) ? LATCH : GUARD;
        end
      end
      GUARD: begin
        if (cnt_q == guard_s - 4'd1) state_d = LATCH;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      LATCH: state_d = ARM;
      ARM: begin
        tmr_load_c = 1'b1;
        state_d    = NEXT;
      end
      NEXT: begin
        // Next row's shift overlaps the OE window just armed
        if (row_q != '1) begin
          row_d   = row_q + ROW_BITS'(1);
          state_d = SHIFT;
        end else if (plane != 3'd0) begin
          plane_d = plane - 3'd1;
          row_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      x_q          <= '0;
      row_q        <= '0;
      cnt_q        <= '0;
      plane        <= '0;
      frame_sync   <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      latch_enable <= 1'b0;
      busy         <= 1'b0;
      ABCDE        <= '0;
      led_pipe     <= '0;
      ppr_s        <= '0;
      base_s       <= '0;
      bright_s     <= '0;
      guard_s      <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      plane        <= plane_d;
      frame_sync   <= (state_d == START);
      rd_en        <= (state_d == SHIFT);
      rd_addr      <= {row_d, x_d};
      latch_enable <= (state_d == LATCH);
      busy         <= (state_d != IDLE);
      led_pipe     <= (led_pipe << 1) | RD_LAT'(rd_en);
      if (state_d == LATCH) ABCDE <= row_q;
      // Frame configuration is frozen for the whole frame
      if ((state_q == IDLE) && (state_d == START)) begin
        ppr_s    <= pixels_per_row;
        base_s   <= bcm_base;
        bright_s <= brightness;
        guard_s  <= guard;
      end
    end
  end

endmodule

// File: tb/tb_h75_scan_engine.sv
// Scoreboard bench for h75_scan_engine: stimulus queues expected row latches,
// a negedge monitor checks latch order, pulse counts, on-times and guard gaps.
module tb_h75_scan_engine;

  localparam int unsigned RB = 2;
  localparam int unsigned PL = 2;
  localparam int unsigned XB = 7;
  localparam int unsigned RL = 3;
  localparam int unsigned BW = 12;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              gen_timing = 1'b0;
  logic [XB:0]       ppr = '0;
  logic [BW-1:0]     base = '0;
  logic [7:0]        bright = '0;
  logic [3:0]        guard = '0;
  logic              frame_sync, rd_en, oe_n, latch_enable, led_clk_en, busy;
  logic [2:0]        plane;
  logic [RB+XB-1:0]  rd_addr;
  logic [RB-1:0]     ABCDE;

  always #5 clk = ~clk;

  h75_scan_engine #(
    .ROW_BITS(RB), .PLANES(PL), .X_BITS(XB), .RD_LAT(RL), .BASE_W(BW)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .gen_timing     (gen_timing),
    .pixels_per_row (ppr),
    .bcm_base       (base),
    .brightness     (bright),
    .guard          (guard),
    .frame_sync     (frame_sync),
    .plane          (plane),
    .rd_addr        (rd_addr),
    .rd_en          (rd_en),
    .oe_n           (oe_n),
    .latch_enable   (latch_enable),
    .led_clk_en     (led_clk_en),
    .ABCDE          (ABCDE),
    .busy           (busy)
  );

  typedef struct {
    int row;
    int pl;
    int on;
    int ppr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   guard_cfg = 0;
  int   frames = 0;
  int   latches = 0;
  logic flush_req = 1'b0;

  int   m_oe_acc = 0, m_prev_on = 0, m_led_cnt = 0, m_since_rise = 0;
  int   m_fs_len = 0, m_cyc = 0, m_rd_rise = 0, m_x_exp = 0;
  logic m_have_prev = 1'b0, m_oe_prev = 1'b1, m_fs_prev = 1'b0;
  logic m_rd_prev = 1'b0, m_led_prev = 1'b0;
  exp_t m_e;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_ge(input string name, input longint act, input longint lim);
    checks++;
    if (act < lim) begin
      failures++;
      $display("FAIL %s: got %0d expected >= %0d at %0t", name, act, lim, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Monitor: consumes one expected record per latch pulse
  initial begin : monitor
    forever begin
      @(negedge clk);
      m_cyc++;
      if (!resetn) begin
        exp_q.delete();
        m_have_prev = 1'b0; m_oe_acc = 0; m_led_cnt = 0; m_fs_len = 0;
        m_oe_prev = 1'b1; m_fs_prev = 1'b0; m_rd_prev = 1'b0; m_led_prev = 1'b0;
        continue;
      end
      if (!oe_n) m_oe_acc++;
      if (oe_n && !m_oe_prev) m_since_rise = 0;
      else m_since_rise++;
      if (led_clk_en) m_led_cnt++;
      if (rd_en && !m_rd_prev) begin
        m_rd_rise = m_cyc;
        m_x_exp   = 0;
      end
      if (led_clk_en && !m_led_prev) check("led_latency", m_cyc - m_rd_rise, RL);
      if (rd_en) begin
        if (exp_q.size() == 0) fail("rd_en_unexpected");
        else check("rd_addr", rd_addr, (exp_q[0].row << XB) | m_x_exp);
        m_x_exp++;
      end
      if (frame_sync) m_fs_len++;
      if (!frame_sync && m_fs_prev) begin
        check("frame_sync_len", m_fs_len, 4);
        m_fs_len = 0;
      end
      if ((frame_sync && !m_fs_prev) || flush_req) begin
        if (frame_sync && !m_fs_prev) frames++;
        check("oe_time_tail", m_oe_acc, m_have_prev ? m_prev_on : 0);
        m_have_prev = 1'b0;
        m_oe_acc    = 0;
      end
      if (latch_enable) begin
        latches++;
        if (exp_q.size() == 0) begin
          fail("latch_unexpected");
        end else begin
          m_e = exp_q.pop_front();
          check("abcde", ABCDE, m_e.row);
          check("plane", plane, m_e.pl);
          check("led_pulses", m_led_cnt, m_e.ppr);
          check("oe_time", m_oe_acc, m_have_prev ? m_prev_on : 0);
          if (m_have_prev && m_prev_on > 0) check_ge("guard_gap", m_since_rise, guard_cfg);
          m_prev_on   = m_e.on;
          m_have_prev = 1'b1;
        end
        m_led_cnt = 0;
        m_oe_acc  = 0;
      end
      m_oe_prev  = oe_n;
      m_fs_prev  = frame_sync;
      m_rd_prev  = rd_en;
      m_led_prev = led_clk_en;
    end
  end

  task automatic push_frame(input int p_ppr, input int on_hi, input int on_lo);
    exp_t e;
    for (int p = PL - 1; p >= 0; p--) begin
      for (int r = 0; r < (1 << RB); r++) begin
        e.row = r;
        e.pl  = p;
        e.on  = (p == PL - 1) ? on_hi : on_lo;
        e.ppr = p_ppr;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic set_cfg(input int p_ppr, input int p_base, input int p_bright, input int p_guard);
    ppr       = (XB + 1)'(p_ppr);
    base      = BW'(p_base);
    bright    = 8'(p_bright);
    guard     = 4'(p_guard);
    guard_cfg = p_guard;
  endtask

  task automatic wait_frame_sync(input string name);
    int n = 0;
    while (!frame_sync && n < 3000) begin @(negedge clk); n++; end
    if (!frame_sync) fail(name);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(busy == 1'b0 && oe_n == 1'b1) && n < 20000) begin @(negedge clk); n++; end
    if (busy != 1'b0 || oe_n != 1'b1) fail(name);
  endtask

  task automatic finish_frame();
    repeat (3) @(negedge clk);
    @(posedge clk); flush_req = 1'b1;
    @(posedge clk); flush_req = 1'b0;
    @(negedge clk); #1;
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oe_n"}, oe_n, 1);
    check({tag, "_latch"}, latch_enable, 0);
    check({tag, "_led"}, led_clk_en, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_fsync"}, frame_sync, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_plane"}, plane, 0);
    check({tag, "_abcde"}, ABCDE, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
  endtask

  // One frame; configuration is scrambled after start to show it is held
  task automatic run_frame(input int p_ppr, input int p_base, input int p_bright,
                           input int p_guard, input int on_hi, input int on_lo);
    set_cfg(p_ppr, p_base, p_bright, p_guard);
    push_frame(p_ppr, on_hi, on_lo);
    @(posedge clk); #1 gen_timing = 1'b1;
    wait_frame_sync("frame_start");
    gen_timing = 1'b0;
    ppr    = (XB + 1)'(3);
    base   = BW'(1);
    bright = 8'd17;
    guard  = 4'd9;
    wait_idle("frame_end");
    finish_frame();
  endtask

  initial begin : stimulus
    int f0;
    int n;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Baseline: on-times 15 and 7
    run_frame(4, 8, 255, 0, 15, 7);
    // Zero brightness keeps the panel dark
    run_frame(4, 8, 0, 0, 0, 0);
    // Guard of 5: 16*128>>8=8, 8*128>>8=4
    run_frame(4, 8, 128, 5, 8, 4);
    // Long rows: 6*200>>8=4, 3*200>>8=2
    run_frame(64, 3, 200, 2, 4, 2);

    // Two back-to-back frames with gen_timing held high
    set_cfg(5, 8, 255, 1);
    push_frame(5, 15, 7);
    push_frame(5, 15, 7);
    f0 = frames;
    @(posedge clk); #1 gen_timing = 1'b1;
    wait_frame_sync("b2b_start");
    n = 0;
    while (frames < f0 + 2 && n < 5000) begin @(negedge clk); n++; end
    if (frames < f0 + 2) fail("b2b_second_frame");
    gen_timing = 1'b0;
    wait_idle("b2b_end");
    finish_frame();
    check("b2b_frames", frames - f0, 2);

    // gen_timing dropped at row 1 of the top plane: 10*255>>8=9, 5*255>>8=4
    set_cfg(4, 5, 255, 0);
    push_frame(4, 9, 4);
    f0 = latches;
    @(posedge clk); #1 gen_timing = 1'b1;
    wait_frame_sync("drop_start");
    n = 0;
    while (latches < f0 + 2 && n < 2000) begin @(negedge clk); n++; end
    if (latches < f0 + 2) fail("drop_row1");
    gen_timing = 1'b0;
    wait_idle("drop_end");
    finish_frame();
    f0 = frames;
    repeat (60) @(negedge clk);
    check("drop_no_new_frame", frames, f0);
    check("drop_busy_low", busy, 0);

    // Reset pulsed while the panel is lit
    set_cfg(4, 8, 255, 0);
    push_frame(4, 15, 7);
    @(posedge clk); #1 gen_timing = 1'b1;
    wait_frame_sync("rst_start");
    n = 0;
    while (oe_n && n < 2000) begin @(negedge clk); n++; end
    if (oe_n) fail("rst_oe_low");
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1 check("rst_async_oe_n", oe_n, 1);
    gen_timing = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Clean frame after reset release
    run_frame(4, 8, 255, 3, 15, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
